// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU share arbiter: FSM states, request payload and the
// subset of cv32e40p ALU operator encodings used by this block.
package alu_arb_pkg;

  localparam int unsigned ALU_OP_W = 7;
  localparam int unsigned DATA_W   = 32;

  // Encodings match cv32e40p_pkg so the block builds without the core sources.
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_SLTS = 7'b0000010,
    ALU_SLTU = 7'b0000011,
    ALU_AND  = 7'b0010101,
    ALU_ADD  = 7'b0011000,
    ALU_SUB  = 7'b0011001,
    ALU_OR   = 7'b0101110,
    ALU_XOR  = 7'b0101111,
    ALU_DIVU = 7'b0110000,
    ALU_DIV  = 7'b0110001,
    ALU_REMU = 7'b0110010,
    ALU_REM  = 7'b0110011
  } alu_opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ALU_OP_W-1:0] operator;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic [DATA_W-1:0]   c;
  } req_payload_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester searching upward
// from ptr_i+1 (mod NUM_REQ).
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    id_o,
  output logic               any_o
);

  int unsigned idx;

  always_comb begin
    grant_o = '0;
    id_o    = '0;
    any_o   = 1'b0;
    idx     = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(ptr_i) + i) % NUM_REQ;
      if (!any_o && valid_i[ID_W'(idx)]) begin
        any_o                = 1'b1;
        grant_o[ID_W'(idx)]  = 1'b1;
        id_o                 = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NUM_REQ requesters: round-robin accept, hold operands
// through multi-cycle ops, return the captured result on a response channel.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ*ALU_OP_W-1:0]  req_operator_i,
  input  logic [NUM_REQ*DATA_W-1:0]    req_op_a_i,
  input  logic [NUM_REQ*DATA_W-1:0]    req_op_b_i,
  input  logic [NUM_REQ*DATA_W-1:0]    req_op_c_i,
  output logic                         resp_valid_o,
  output logic [ID_W-1:0]              resp_id_o,
  output logic [DATA_W-1:0]            resp_result_o,
  output logic                         resp_cmp_o,
  input  logic                         resp_ready_i,
  output logic                         alu_enable_o,
  output logic [ALU_OP_W-1:0]          alu_operator_o,
  output logic [DATA_W-1:0]            alu_op_a_o,
  output logic [DATA_W-1:0]            alu_op_b_o,
  output logic [DATA_W-1:0]            alu_op_c_o,
  output logic                         alu_ex_ready_o,
  input  logic [DATA_W-1:0]            alu_result_i,
  input  logic                         alu_cmp_i,
  input  logic                         alu_ready_i
);

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, id_q, win_id;
  logic [NUM_REQ-1:0]  grant;
  logic                win_any;
  req_payload_t        pay_q, win_pay;
  logic [DATA_W-1:0]   result_q;
  logic                cmp_q;
  logic                accept, capture;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .valid_i (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .id_o    (win_id),
    .any_o   (win_any)
  );

  // Unpack the winning requester's slot.
  always_comb begin
    win_pay = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        win_pay.operator = req_operator_i[k*ALU_OP_W +: ALU_OP_W];
        win_pay.a        = req_op_a_i[k*DATA_W +: DATA_W];
        win_pay.b        = req_op_b_i[k*DATA_W +: DATA_W];
        win_pay.c        = req_op_c_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; req_ready is only offered while idle.
  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    accept      = 1'b0;
    capture     = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = grant;
        if (win_any) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (alu_ready_i) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= ID_W'(NUM_REQ - 1);
      id_q     <= '0;
      pay_q    <= '0;
      result_q <= '0;
      cmp_q    <= 1'b0;
    end else begin
      if (accept) begin
        pay_q    <= win_pay;
        id_q     <= win_id;
        rr_ptr_q <= win_id;
      end
      if (capture) begin
        result_q <= alu_result_i;
        cmp_q    <= alu_cmp_i;
      end
    end
  end

  // Outputs decode straight from registered state so they are zero outside their phase.
  assign alu_enable_o   = (state_q == EXEC);
  assign alu_ex_ready_o = (state_q == EXEC);
  assign alu_operator_o = alu_enable_o ? pay_q.operator : '0;
  assign alu_op_a_o     = alu_enable_o ? pay_q.a : '0;
  assign alu_op_b_o     = alu_enable_o ? pay_q.b : '0;
  assign alu_op_c_o     = alu_enable_o ? pay_q.c : '0;

  assign resp_valid_o   = (state_q == RESP);
  assign resp_id_o      = resp_valid_o ? id_q : '0;
  assign resp_result_o  = resp_valid_o ? result_q : '0;
  assign resp_cmp_o     = resp_valid_o ? cmp_q : 1'b0;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: ALU stub, request/response drivers and a
// transaction-level round-robin scoreboard.
module tb_alu_share_arbiter;
  import alu_arb_pkg::*;

  localparam int unsigned N    = 2;
  localparam int unsigned ID_W = 1;
  localparam int unsigned OPW  = ALU_OP_W;

  logic                clk, rst;
  logic [N-1:0]        req_valid_i, req_ready_o;
  logic [N*OPW-1:0]    req_operator_i;
  logic [N*32-1:0]     req_op_a_i, req_op_b_i, req_op_c_i;
  logic                resp_valid_o, resp_cmp_o, resp_ready_i;
  logic [ID_W-1:0]     resp_id_o;
  logic [31:0]         resp_result_o;
  logic                alu_enable_o, alu_ex_ready_o, alu_cmp_i, alu_ready_i;
  logic [OPW-1:0]      alu_operator_o;
  logic [31:0]         alu_op_a_o, alu_op_b_o, alu_op_c_o, alu_result_i;

  alu_share_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_operator_i(req_operator_i), .req_op_a_i(req_op_a_i),
    .req_op_b_i(req_op_b_i), .req_op_c_i(req_op_c_i),
    .resp_valid_o(resp_valid_o), .resp_id_o(resp_id_o),
    .resp_result_o(resp_result_o), .resp_cmp_o(resp_cmp_o),
    .resp_ready_i(resp_ready_i),
    .alu_enable_o(alu_enable_o), .alu_operator_o(alu_operator_o),
    .alu_op_a_o(alu_op_a_o), .alu_op_b_o(alu_op_b_o), .alu_op_c_o(alu_op_c_o),
    .alu_ex_ready_o(alu_ex_ready_o), .alu_result_i(alu_result_i),
    .alu_cmp_i(alu_cmp_i), .alu_ready_i(alu_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [OPW-1:0] op;
    logic [31:0] a, b, c;
    logic [31:0] res;
    logic        cmp;
  } txn_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_div(input logic [OPW-1:0] op);
    return (op == ALU_DIVU) || (op == ALU_DIV) || (op == ALU_REMU) || (op == ALU_REM);
  endfunction

  // Architectural ALU behaviour: returns {cmp, result}.
  function automatic logic [32:0] ref_alu(input logic [OPW-1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    logic        c;
    logic        ovf;
    r   = 32'h0;
    c   = 1'b0;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLTS: begin c = ($signed(a) < $signed(b)); r = {31'h0, c}; end
      ALU_SLTU: begin c = (a < b); r = {31'h0, c}; end
      ALU_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_DIV:  r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      ALU_REMU: r = (b == 0) ? a : a % b;
      ALU_REM:  r = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default:  r = 32'h0;
    endcase
    return {c, r};
  endfunction

  // Bench-side state
  txn_t        pend [N][$];
  txn_t        expq [$];
  int          grant_log [$];
  logic [31:0] res_log [$];
  int          m_last, cyc, hs_c, acc_c, regrant_gap;
  bit          busy, prev_rv;
  logic [N-1:0] acc_seen;
  logic [31:0] last_res;
  logic        last_cmp;
  int          last_id;
  int          rdy_pct, present_pct, force_div_len, last_exec;
  bit          hold_resp;

  // ALU stub: single-cycle ops ready at once, div/rem ready after div_len extra cycles.
  int exec_cyc, div_len;
  initial begin
    alu_ready_i  = 1'b1;
    alu_result_i = 32'h0;
    alu_cmp_i    = 1'b0;
    exec_cyc     = 0;
    div_len      = 0;
    forever begin
      @(posedge clk);
      #1;
      if (alu_enable_o) begin
        exec_cyc++;
        if (exec_cyc == 1)
          div_len = !is_div(alu_operator_o) ? 0 :
                    (force_div_len > 0) ? force_div_len : int'($urandom_range(1, 6));
        alu_ready_i = (exec_cyc > div_len);
        if (alu_ready_i) {alu_cmp_i, alu_result_i} = ref_alu(alu_operator_o, alu_op_a_o, alu_op_b_o);
        else begin alu_result_i = 32'hDEAD_BEEF; alu_cmp_i = 1'b0; end
      end else begin
        if (exec_cyc != 0) last_exec = exec_cyc;
        exec_cyc     = 0;
        alu_ready_i  = 1'b1;
        alu_result_i = 32'hDEAD_BEEF;
        alu_cmp_i    = 1'b0;
      end
    end
  end

  initial begin
    resp_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      resp_ready_i = !hold_resp && (int'($urandom_range(0, 99)) < rdy_pct);
    end
  end

  // Requesters: hold valid+payload until the handshake seen at the previous edge.
  initial begin
    req_valid_i    = '0;
    req_operator_i = '0;
    req_op_a_i     = '0;
    req_op_b_i     = '0;
    req_op_c_i     = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        for (int k = 0; k < int'(N); k++) begin
          if (acc_seen[k] && req_valid_i[k]) begin
            req_valid_i[k] = 1'b0;
            if (pend[k].size() > 0) void'(pend[k].pop_front());
          end
          if (!req_valid_i[k] && pend[k].size() > 0 &&
              int'($urandom_range(0, 99)) < present_pct) begin
            req_operator_i[k*OPW +: OPW] = pend[k][0].op;
            req_op_a_i[k*32 +: 32]       = pend[k][0].a;
            req_op_b_i[k*32 +: 32]       = pend[k][0].b;
            req_op_c_i[k*32 +: 32]       = pend[k][0].c;
            req_valid_i[k]               = 1'b1;
          end
        end
      end
    end
  end

  // Scoreboard: round-robin over currently valid requesters, one op in flight.
  int          exp_id;
  bit          found;
  logic [N-1:0] exp_rdy;
  txn_t        t;
  always @(negedge clk) begin
    if (rst) begin
      acc_seen = '0;
      prev_rv  = 1'b0;
    end else begin
      cyc++;
      check("ready_onehot", 32'($countones(req_ready_o) <= 1), 32'd1);
      if (busy) begin
        check("ready_while_busy", 32'(req_ready_o), 32'd0);
        if (resp_valid_o) begin
          check("alu_en_in_resp", 32'(alu_enable_o), 32'd0);
          check("resp_id", 32'(resp_id_o), 32'(expq[0].id));
          check("resp_result", resp_result_o, expq[0].res);
          check("resp_cmp", 32'(resp_cmp_o), 32'(expq[0].cmp));
          if (!prev_rv && !is_div(expq[0].op)) check("latency", 32'(cyc - hs_c), 32'd2);
          if (resp_ready_i) begin
            last_res = resp_result_o;
            last_cmp = resp_cmp_o;
            last_id  = int'(resp_id_o);
            res_log.push_back(resp_result_o);
            void'(expq.pop_front());
            busy  = 1'b0;
            acc_c = cyc;
          end
        end else begin
          check("alu_en_exec", 32'(alu_enable_o), 32'd1);
          check("alu_ex_ready", 32'(alu_ex_ready_o), 32'd1);
          check("alu_operator", 32'(alu_operator_o), 32'(expq[0].op));
          check("alu_op_a", alu_op_a_o, expq[0].a);
          check("alu_op_b", alu_op_b_o, expq[0].b);
          check("alu_op_c", alu_op_c_o, expq[0].c);
        end
      end else begin
        check("resp_valid_idle", 32'(resp_valid_o), 32'd0);
        check("alu_en_idle", 32'(alu_enable_o), 32'd0);
        found  = 1'b0;
        exp_id = 0;
        for (int i = 1; i <= int'(N); i++) begin
          if (!found && req_valid_i[(m_last + i) % N]) begin
            found  = 1'b1;
            exp_id = (m_last + i) % N;
          end
        end
        exp_rdy = '0;
        if (found) exp_rdy[exp_id] = 1'b1;
        check("grant", 32'(req_ready_o), 32'(exp_rdy));
        if (found) begin
          t    = pend[exp_id][0];
          t.id = exp_id;
          {t.cmp, t.res} = ref_alu(t.op, t.a, t.b);
          expq.push_back(t);
          grant_log.push_back(exp_id);
          m_last      = exp_id;
          busy        = 1'b1;
          hs_c        = cyc;
          regrant_gap = cyc - acc_c;
        end
      end
      prev_rv  = resp_valid_o;
      acc_seen = req_valid_i & req_ready_o;
    end
  end

  task automatic push(input int k, input logic [OPW-1:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    txn_t x;
    x.id = k; x.op = op; x.a = a; x.b = b; x.c = $urandom(); x.res = '0; x.cmp = 1'b0;
    pend[k].push_back(x);
  endtask

  task automatic flush_model();
    for (int k = 0; k < int'(N); k++) pend[k].delete();
    expq.delete();
    req_valid_i = '0;
    busy        = 1'b0;
    m_last      = int'(N) - 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush_model();
    #1;
    check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    check("rst_req_ready", 32'(req_ready_o), 32'd0);
    check("rst_alu_en", 32'(alu_enable_o), 32'd0);
    check("rst_resp_result", resp_result_o, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      #1;
      if (pend[0].size() == 0 && pend[1].size() == 0 && !busy && req_valid_i == '0) return;
    end
    check("drain_timeout", 32'(pend[0].size() + pend[1].size() + expq.size()), 32'd0);
  endtask

  logic [OPW-1:0] op_tab [11] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLTS,
                                   ALU_SLTU, ALU_DIVU, ALU_DIV, ALU_REMU, ALU_REM};

  initial begin
    rst = 1'b1; cyc = 0; hs_c = 0; acc_c = 0; regrant_gap = 0; busy = 1'b0; prev_rv = 1'b0;
    acc_seen = '0; last_res = '0; last_cmp = 1'b0; last_id = 0; last_exec = 0;
    rdy_pct = 100; present_pct = 100; force_div_len = 0; hold_resp = 1'b0;
    m_last = int'(N) - 1;
    do_reset();

    // Single ADD from requester 0
    push(0, ALU_ADD, 32'd5, 32'd7);
    wait_done(50);
    check("t1_result", last_res, 32'd12);
    check("t1_id", 32'(last_id), 32'd0);

    // Simultaneous pairs from reset alternate 0,1,0,1
    do_reset();
    grant_log.delete(); res_log.delete();
    push(0, ALU_SUB, 32'd10, 32'd3);
    push(1, ALU_ADD, 32'd1, 32'd1);
    wait_done(50);
    push(0, ALU_XOR, $urandom(), $urandom());
    push(1, ALU_OR, $urandom(), $urandom());
    wait_done(50);
    check("t2_count", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4 && res_log.size() == 4) begin
      check("t2_first", 32'(grant_log[0]), 32'd0);
      check("t2_second", 32'(grant_log[1]), 32'd1);
      check("t2_third", 32'(grant_log[2]), 32'd0);
      check("t2_fourth", 32'(grant_log[3]), 32'd1);
      check("t2_res0", res_log[0], 32'd7);
      check("t2_res1", res_log[1], 32'd2);
    end

    // Multi-cycle DIVU on requester 1
    force_div_len = 4;
    push(1, ALU_DIVU, 32'd100, 32'd7);
    wait_done(80);
    check("t3_result", last_res, 32'd14);
    check("t3_id", 32'(last_id), 32'd1);
    check("t3_exec_len", 32'(last_exec), 32'd5);
    force_div_len = 0;

    // Response backpressure: no new grant while the result waits
    hold_resp = 1'b1;
    @(posedge clk); #2;
    push(0, ALU_ADD, 32'd3, 32'd4);
    push(0, ALU_SUB, 32'd9, 32'd1);
    for (int i = 0; i < 20 && !resp_valid_o; i++) @(negedge clk);
    check("t4_resp_seen", 32'(resp_valid_o), 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("t4_hold_valid", 32'(resp_valid_o), 32'd1);
      check("t4_hold_result", resp_result_o, 32'd7);
      check("t4_no_grant", 32'(req_ready_o), 32'd0);
    end
    hold_resp = 1'b0;
    wait_done(50);
    check("t4_regrant_gap", 32'(regrant_gap), 32'd1);
    check("t4_last", last_res, 32'd8);

    // Reset in the middle of a long DIV discards it
    force_div_len = 30;
    push(0, ALU_DIV, 32'hFFFF_FF9C, 32'd7);
    for (int i = 0; i < 20 && !alu_enable_o; i++) @(negedge clk);
    check("t5_exec_seen", 32'(alu_enable_o), 32'd1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    flush_model();
    #1;
    check("t5_alu_en", 32'(alu_enable_o), 32'd0);
    check("t5_alu_a", alu_op_a_o, 32'd0);
    check("t5_alu_op", 32'(alu_operator_o), 32'd0);
    check("t5_resp_valid", 32'(resp_valid_o), 32'd0);
    @(negedge clk);
    check("t5_resp_valid_edge", 32'(resp_valid_o), 32'd0);
    check("t5_alu_en_edge", 32'(alu_enable_o), 32'd0);
    #2 rst = 1'b0;
    force_div_len = 0;
    grant_log.delete();
    push(0, ALU_ADD, 32'd2, 32'd2);
    push(1, ALU_ADD, 32'd3, 32'd3);
    wait_done(50);
    if (grant_log.size() > 0) check("t5_first_after_rst", 32'(grant_log[0]), 32'd0);
    else check("t5_grants", 32'(grant_log.size()), 32'd2);

    // Signed compare
    push(1, ALU_SLTS, 32'hFFFF_FFFF, 32'd1);
    wait_done(50);
    check("t6_result", last_res, 32'd1);
    check("t6_cmp", 32'(last_cmp), 32'd1);

    // Randomised traffic with response backpressure
    rdy_pct = 60; present_pct = 50;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom();
      push(int'($urandom_range(0, N - 1)), op_tab[$urandom_range(0, 10)], a, b);
    end
    wait_done(20000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
